// File: rtl/tone_divider_bank.sv
// tone_divider_bank: multi-channel square-wave tone generator.
// Frequencies arrive in Hz; one shared serial restoring divider turns each into
// a period P = CLK_HZ / freq. Each channel adopts its new period only at a
// period boundary (or immediately if it is stopped), so retuning never glitches.
module tone_divider_bank #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  // Channel-select width; may be widened so that out-of-range selects are representable.
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                in_clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CH_W-1:0]     wr_chan,
  input  logic [WIDTH-1:0]    wr_freq,
  input  logic [CHANNELS-1:0] chan_en,
  output logic [CHANNELS-1:0] tone_out,
  output logic [CHANNELS-1:0] pending
);

  localparam int               IT_W     = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] DIVIDEND = WIDTH'(CLK_HZ);
  localparam logic [IT_W-1:0]  LAST_IT  = IT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_STORE
  } div_state_e;

  div_state_e       state_q;
  logic             wr_ready_q;
  logic [CH_W-1:0]  chan_q;
  logic [WIDTH-1:0] freq_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [IT_W-1:0]  it_q;

  logic [WIDTH:0]   rem_shift_d;
  logic [WIDTH-1:0] rem_diff_d;
  logic             quo_bit_d;

  logic             store_fire;
  logic [WIDTH-1:0] store_val;

  // One restoring step: bring in the next dividend bit and try to subtract the divisor.
  always_comb begin
    rem_shift_d = {rem_q, dvd_q[WIDTH-1]};
    quo_bit_d   = (rem_shift_d >= {1'b0, freq_q});
    // Only used when the subtraction succeeds, so the result always fits WIDTH bits.
    rem_diff_d  = rem_shift_d[WIDTH-1:0] - freq_q;
  end

  // Periods below 2 cannot form a square wave; they (and freq == 0) mean silence.
  assign store_fire = (state_q == ST_STORE);
  assign store_val  = (quo_q < WIDTH'(2)) ? '0 : quo_q;
  assign wr_ready   = wr_ready_q;

  // Divider FSM: latch a write, run WIDTH quotient steps MSB first, then hand off in STORE.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ready_q <= 1'b1;
      chan_q     <= '0;
      freq_q     <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      it_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wr_valid && wr_ready_q) begin
            chan_q     <= wr_chan;
            freq_q     <= wr_freq;
            dvd_q      <= DIVIDEND;
            rem_q      <= '0;
            quo_q      <= '0;
            it_q       <= '0;
            wr_ready_q <= 1'b0;
            state_q    <= ST_DIV;
          end
        end
        ST_DIV: begin
          // A zero divisor keeps the quotient at 0 but still spends the full step count.
          if (freq_q != '0) begin
            rem_q <= quo_bit_d ? rem_diff_d : rem_shift_d[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], quo_bit_d};
          end
          dvd_q <= dvd_q << 1;
          it_q  <= it_q + 1'b1;
          if (it_q == LAST_IT) begin
            state_q <= ST_STORE;
          end
        end
        ST_STORE: begin
          wr_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          wr_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] per_q;
      logic [WIDTH-1:0] cnt_q;
      logic [WIDTH-1:0] pend_q;
      logic             pend_flag_q;
      logic             tone_q;
      logic             running;
      logic             wrap;
      logic             store_hit;

      assign running   = chan_en[gi] && (per_q != '0);
      assign wrap      = (cnt_q == per_q - WIDTH'(1));
      // Selects at or beyond CHANNELS match no channel and are dropped here.
      assign store_hit = store_fire && (chan_q == CH_W'(gi));

      // Channel state: apply pending period at a wrap (or at once when stopped), count, drive tone.
      always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
          per_q       <= '0;
          cnt_q       <= '0;
          pend_q      <= '0;
          pend_flag_q <= 1'b0;
          tone_q      <= 1'b0;
        end else begin
          if (pend_flag_q && (!running || wrap)) begin
            per_q       <= pend_q;
            cnt_q       <= '0;
            pend_flag_q <= 1'b0;
          end else if (running) begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
          end
          // A fresh result landing on the apply edge stays pending; the older value is what applied.
          if (store_hit) begin
            pend_q      <= store_val;
            pend_flag_q <= 1'b1;
          end
          tone_q <= running && (cnt_q < (per_q >> 1));
        end
      end

      assign tone_out[gi] = tone_q;
      assign pending[gi]  = pend_flag_q;
    end
  endgenerate

endmodule

// File: tb/tb_tone_divider_bank.sv
// tb_tone_divider_bank: directed scenarios plus randomized writes/enables, every
// cycle compared with a timestamp-based reference model of the tone bank.
module tb_tone_divider_bank;

  localparam int CLK_HZ   = 50_000_000;
  localparam int CHANNELS = 4;
  localparam int WIDTH    = 32;
  localparam int CH_W     = 3;  // wide enough to present out-of-range channel 5

  logic                in_clk;
  logic                rst_n;
  logic                wr_valid;
  logic                wr_ready;
  logic [CH_W-1:0]     wr_chan;
  logic [WIDTH-1:0]    wr_freq;
  logic [CHANNELS-1:0] chan_en;
  logic [CHANNELS-1:0] tone_out;
  logic [CHANNELS-1:0] pending;

  tone_divider_bank #(
    .CLK_HZ  (CLK_HZ),
    .CHANNELS(CHANNELS),
    .WIDTH   (WIDTH),
    .CH_W    (CH_W)
  ) dut (
    .in_clk  (in_clk),
    .rst_n   (rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_chan (wr_chan),
    .wr_freq (wr_freq),
    .chan_en (chan_en),
    .tone_out(tone_out),
    .pending (pending)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h time=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each running channel's phase is (edge - start) mod P.
  longint      n;
  int unsigned m_per  [CHANNELS];
  int unsigned m_pval [CHANNELS];
  longint      m_start[CHANNELS];
  bit          m_pend [CHANNELS];
  bit          m_tone [CHANNELS];
  bit          m_busy;
  longint      m_done;
  int          m_chan;
  int unsigned m_p;

  function automatic int unsigned ref_period(input logic [WIDTH-1:0] f);
    int unsigned q;
    if (f == 0) return 0;
    q = int'(CLK_HZ) / f;
    return (q < 2) ? 0 : q;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < CHANNELS; c++) begin
      m_per[c] = 0; m_pval[c] = 0; m_start[c] = n; m_pend[c] = 0; m_tone[c] = 0;
    end
    m_busy = 0; m_done = 0; m_chan = 0; m_p = 0;
  endtask

  task automatic compare_all();
    logic [CHANNELS-1:0] et;
    logic [CHANNELS-1:0] ep;
    for (int c = 0; c < CHANNELS; c++) begin
      et[c] = m_tone[c];
      ep[c] = m_pend[c];
    end
    check("tone_out", tone_out, et);
    check("pending", pending, ep);
    check("wr_ready", wr_ready, !m_busy);
  endtask

  // Advance one clock: predict from current inputs, take the edge, then compare.
  task automatic tick();
    int unsigned n_per [CHANNELS];
    int unsigned n_pval[CHANNELS];
    longint      n_start[CHANNELS];
    bit          n_pend[CHANNELS];
    bit          n_tone[CHANNELS];
    bit          n_busy;
    longint      n_done;
    int          n_chan;
    int unsigned n_p;
    bit          run;
    longint      pos;
    n_busy = m_busy; n_done = m_done; n_chan = m_chan; n_p = m_p;
    for (int c = 0; c < CHANNELS; c++) begin
      n_per[c] = m_per[c]; n_pval[c] = m_pval[c]; n_start[c] = m_start[c]; n_pend[c] = m_pend[c];
      run = chan_en[c] && (m_per[c] != 0);
      pos = run ? (n - m_start[c]) % longint'(m_per[c]) : 0;
      n_tone[c] = run && (pos < longint'(m_per[c] / 2));
      if (m_pend[c] && (!run || pos == longint'(m_per[c]) - 1)) begin
        n_per[c] = m_pval[c]; n_start[c] = n + 1; n_pend[c] = 0;
      end else if (!run) begin
        n_start[c] = n + 1;
      end
    end
    if (m_busy && (n + 1 == m_done)) begin
      if (m_chan < CHANNELS) begin
        n_pval[m_chan] = m_p;
        n_pend[m_chan] = 1;
      end
      n_busy = 0;
    end
    if (wr_valid && !m_busy) begin
      n_busy = 1;
      n_done = n + 2 + WIDTH;
      n_chan = int'(wr_chan);
      n_p    = ref_period(wr_freq);
      $display("write ch=%0d freq=%0d period=%0d", n_chan, wr_freq, n_p);
    end
    @(posedge in_clk);
    #1;
    n++;
    for (int c = 0; c < CHANNELS; c++) begin
      m_per[c] = n_per[c]; m_pval[c] = n_pval[c]; m_start[c] = n_start[c];
      m_pend[c] = n_pend[c]; m_tone[c] = n_tone[c];
    end
    m_busy = n_busy; m_done = n_done; m_chan = n_chan; m_p = n_p;
    compare_all();
  endtask

  task automatic write_chan(input int ch, input logic [WIDTH-1:0] f);
    for (int i = 0; i < WIDTH + 4 && m_busy; i++) tick();
    wr_valid = 1'b1;
    wr_chan  = CH_W'(ch);
    wr_freq  = f;
    tick();
    wr_valid = 1'b0;
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic async_reset();
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    check("areset_tone", tone_out, '0);
    check("areset_pend", pending, '0);
    check("areset_ready", wr_ready, 1'b1);
    @(posedge in_clk);
    @(negedge in_clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  bit even_seq[8]     = '{1, 1, 0, 0, 1, 1, 0, 0};
  bit odd_seq[10]     = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
  bit retune_seq[12]  = '{1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    int lowcnt;
    int r;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_chan  = '0;
    wr_freq  = '0;
    chan_en  = '0;
    n        = 0;
    clear_model();
    @(posedge in_clk);
    #1;
    check("reset_tone", tone_out, '0);
    check("reset_pend", pending, '0);
    check("reset_ready", wr_ready, 1'b1);
    chan_en = 4'b0001;
    @(negedge in_clk);
    rst_n = 1'b1;

    // Even period on ch0: P=4
    write_chan(0, 32'd12_500_000);
    repeat (32) tick();
    check("even_pend_early", pending[0], 1'b0);
    tick();
    check("even_pend_rise", pending[0], 1'b1);
    check("even_ready_back", wr_ready, 1'b1);
    tick();
    check("even_applied", pending[0], 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("even_wave", tone_out[0], even_seq[i]);
    end

    // Odd period on ch1: P=5, high 2 low 3
    chan_en = 4'b0011;
    write_chan(1, 32'd10_000_000);
    repeat (33) tick();
    check("odd_pend_rise", pending[1], 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("odd_wave", tone_out[1], odd_seq[i]);
    end

    // Retune ch0 P=4 -> P=8, result landing at phase 0 of the old period
    for (int i = 0; i < WIDTH + 4 && m_busy; i++) tick();
    for (int i = 0; i < 4 && ((n + WIDTH + 2 - m_start[0]) % 4 != 0); i++) tick();
    write_chan(0, 32'd6_250_000);
    repeat (33) tick();
    check("retune_pend", pending[0], 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("retune_wave", tone_out[0], retune_seq[i]);
    end

    // Silence: freq 0 on ch0, P=1 on ch1
    write_chan(0, 32'd0);
    repeat (33 + 10) tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("silence_f0", tone_out[0], 1'b0);
    end
    write_chan(1, 32'd30_000_000);
    repeat (33 + 8) tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("silence_p1", tone_out[1], 1'b0);
    end

    // Back-to-back handshake with wr_valid held high
    for (int i = 0; i < WIDTH + 4 && m_busy; i++) tick();
    wr_valid = 1'b1;
    wr_chan  = 3'd2;
    wr_freq  = 32'd5_000_000;
    tick();
    check("hs_accept1", wr_ready, 1'b0);
    wr_chan = 3'd3;
    wr_freq = 32'd6_250_000;
    lowcnt  = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wr_ready === 1'b1) break;
      lowcnt++;
    end
    check("hs_low_cycles", lowcnt, 33);
    tick();
    check("hs_accept2", wr_ready, 1'b0);
    wr_valid = 1'b0;
    repeat (40) tick();

    // Out-of-range channel is discarded
    write_chan(5, 32'd12_500_000);
    repeat (34) tick();
    check("oor_pending", pending, '0);
    check("oor_ready", wr_ready, 1'b1);

    // Reset in the middle of a division drops the write
    write_chan(0, 32'd12_500_000);
    repeat (10) tick();
    async_reset();
    repeat (40) tick();
    check("abort_pend", pending, '0);

    // Randomized writes, channels (including out-of-range) and enables
    chan_en = 4'b1111;
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 9) == 0) chan_en = CHANNELS'($urandom);
      if (it == 125) async_reset();
      if ($urandom_range(0, 1) == 1) begin
        wr_valid = 1'b1;
        wr_chan  = CH_W'($urandom_range(0, 5));
        r = $urandom_range(0, 9);
        if (r == 0)      wr_freq = 32'd0;
        else if (r == 1) wr_freq = 32'd30_000_000;
        else             wr_freq = WIDTH'($urandom_range(1_000_000, 25_000_000));
      end
      tick();
      wr_valid = 1'b0;
      repeat ($urandom_range(0, 12)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
